// File: rtl/bp_ctrl_pkg.sv
// Shared constants, load-sequencer state type and the lane-to-buffer
// index mapping for the buffer-pool load controller.
package bp_ctrl_pkg;

  localparam int X_MAC_DEF            = 4;
  localparam int X_MESH_DEF           = 16;
  localparam int DDR_ADDR_LEN_DEF     = 32;
  localparam int ADDR_LEN_DEF         = 16;
  localparam int DATA_LEN_DEF         = 32;
  localparam int SINGLE_LEN_DEF       = 24;
  localparam int C_AXI_DATA_WIDTH_DEF = 256;
  localparam int BUFFER_NUM_DEF       = X_MAC_DEF * X_MESH_DEF;

  // Idle, filling the first line, filling the second line.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LINE0 = 2'd1,
    ST_LINE1 = 2'd2
  } ld_state_e;

  // Buffer index fed by mesh lane m when writing buffer group n.
  function automatic int buf_index(input int n, input int m, input int x_mac);
    return n + m * x_mac;
  endfunction

endpackage

// File: rtl/bp_beat_pack.sv
// Pairs consecutive AXI beats into one double-width word: the first beat
// of a pair is held, the second completes the word in the same cycle.
module bp_beat_pack #(
  parameter int BEAT_W = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  input  logic [BEAT_W-1:0]   beat_i,
  input  logic                beat_valid_i,
  output logic [2*BEAT_W-1:0] word_o,
  output logic                word_valid_o
);

  logic              half_q;
  logic [BEAT_W-1:0] lo_q;

  // Track whether the low half of a pair is already held; a clear drops it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    if (!rst_n || clear_i) begin
      half_q <= 1'b0;
    end else if (beat_valid_i) begin
      half_q <= !half_q;
    end
  end

  // Capture the low beat of each pair.
  always_ff @(posedge clk) begin
    // NOTE: the data holding register is not reset; half_q alone decides whether it is meaningful.
    if (beat_valid_i && !half_q) begin
      lo_q <= beat_i;
    end
  end

  assign word_o       = {beat_i, lo_q};
  assign word_valid_o = beat_valid_i && half_q && !clear_i;

endmodule

// File: rtl/bp_load_control.sv
// Streams a DDR read into the buffer pool: beats are packed in pairs and
// each packed word is broadcast to one buffer group, two lines per transfer.
module bp_load_control
  import bp_ctrl_pkg::*;
#(
  parameter int X_MAC            = X_MAC_DEF,
  parameter int X_MESH           = X_MESH_DEF,
  parameter int DDR_ADDR_LEN     = DDR_ADDR_LEN_DEF,
  parameter int ADDR_LEN         = ADDR_LEN_DEF,
  parameter int DATA_LEN         = DATA_LEN_DEF,
  parameter int SINGLE_LEN       = SINGLE_LEN_DEF,
  parameter int C_AXI_DATA_WIDTH = C_AXI_DATA_WIDTH_DEF,
  parameter int BUFFER_NUM       = X_MAC * X_MESH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           conf,
  input  logic [SINGLE_LEN-1:0]          data_ddr_byte,
  input  logic [DDR_ADDR_LEN-1:0]        ddr_st_addr,
  input  logic [ADDR_LEN-1:0]            BP_st_addr,
  input  logic [1:0]                     BP_st_num,
  input  logic [SINGLE_LEN-1:0]          Line_width,
  output logic [DDR_ADDR_LEN-1:0]        ddr_st_addr_out,
  output logic [SINGLE_LEN-1:0]          ddr_len,
  output logic                           ddr_conf,
  input  logic [C_AXI_DATA_WIDTH-1:0]    ddr_read_data,
  input  logic                           ddr_read_valid,
  output logic                           ddr_read_ready,
  output logic [ADDR_LEN*BUFFER_NUM-1:0] BP_addr_out,
  output logic [DATA_LEN*BUFFER_NUM-1:0] BP_data_out,
  output logic [BUFFER_NUM-1:0]          BP_we_out,
  output logic                           idle
);

  localparam int WORD_W = 2 * C_AXI_DATA_WIDTH;
  localparam int CNT_W  = SINGLE_LEN + 2;
  localparam logic [SINGLE_LEN-1:0] LW_ONE   = SINGLE_LEN'(1);
  localparam logic [ADDR_LEN-1:0]   ADDR_ONE = ADDR_LEN'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

  ld_state_e             state_q;
  logic                  working_d1_q;
  logic [SINGLE_LEN-1:0] lw_q;
  logic [SINGLE_LEN-1:0] wcnt_q;
  logic [ADDR_LEN-1:0]   st_addr_q;
  logic [ADDR_LEN-1:0]   addr_q;
  logic [1:0]            grp_q;
  logic [CNT_W-1:0]      beats_q;

  logic                           working;
  logic                           beat_acc;
  logic                           word_valid;
  logic                           last_in_line;
  logic [WORD_W-1:0]              word;
  logic [BUFFER_NUM-1:0]          we_mask;
  logic [DATA_LEN*BUFFER_NUM-1:0] data_bcast;

  assign working        = (state_q != ST_IDLE);
  assign ddr_read_ready = working && (beats_q < {lw_q, 2'b00});
  assign beat_acc       = ddr_read_valid && ddr_read_ready;
  assign idle           = !working && !working_d1_q;
  assign last_in_line   = ((wcnt_q + LW_ONE) == lw_q);

  bp_beat_pack #(
    .BEAT_W (C_AXI_DATA_WIDTH)
  ) u_pack (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (conf),
    .beat_i       (ddr_read_data),
    .beat_valid_i (beat_acc),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // Lane m feeds buffer n + m*X_MAC for every group n; only the current group is enabled.
  for (genvar n = 0; n < X_MAC; n++) begin : g_grp
    for (genvar m = 0; m < X_MESH; m++) begin : g_lane
      localparam int B = buf_index(n, m, X_MAC);
      assign we_mask[B] = (grp_q == 2'(n));
      assign data_bcast[B*DATA_LEN +: DATA_LEN] = word[m*DATA_LEN +: DATA_LEN];
    end
  end

  // Transfer sequencer: config latch, beat counting, write issue and line/group stepping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      working_d1_q    <= 1'b0;
      lw_q            <= '0;
      wcnt_q          <= '0;
      st_addr_q       <= '0;
      addr_q          <= '0;
      grp_q           <= '0;
      beats_q         <= '0;
      ddr_conf        <= 1'b0;
      ddr_len         <= '0;
      ddr_st_addr_out <= '0;
      BP_we_out       <= '0;
      BP_addr_out     <= '0;
      BP_data_out     <= '0;
    end else begin
      ddr_conf     <= 1'b0;
      BP_we_out    <= '0;
      working_d1_q <= working;
      if (conf) begin
        state_q         <= ST_LINE0;
        lw_q            <= Line_width;
        st_addr_q       <= BP_st_addr;
        addr_q          <= BP_st_addr;
        grp_q           <= BP_st_num;
        wcnt_q          <= '0;
        beats_q         <= '0;
        ddr_conf        <= 1'b1;
        ddr_len         <= data_ddr_byte;
        ddr_st_addr_out <= ddr_st_addr;
      end else if (working) begin
        if (lw_q == '0) begin
          state_q <= ST_IDLE;
        end
        if (beat_acc) begin
          beats_q <= beats_q + CNT_ONE;
        end
        if (word_valid) begin
          BP_we_out   <= we_mask;
          BP_addr_out <= {BUFFER_NUM{addr_q}};
          BP_data_out <= data_bcast;
          if (last_in_line) begin
            wcnt_q <= '0;
            if (state_q == ST_LINE0) begin
              state_q <= ST_LINE1;
              grp_q   <= grp_q + 2'd1;
              addr_q  <= st_addr_q;
            end else begin
              state_q <= ST_IDLE;
              addr_q  <= '0;
              beats_q <= '0;
            end
          end else begin
            wcnt_q <= wcnt_q + LW_ONE;
            addr_q <= addr_q + ADDR_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bp_load_control.sv
// Directed bench for bp_load_control: config handshake, pair packing,
// group/address stepping, wrap cases, restart, ignored beats and reset abort.
module tb_bp_load_control;

  logic           clk;
  logic           rst_n;
  logic           conf;
  logic [23:0]    data_ddr_byte;
  logic [31:0]    ddr_st_addr;
  logic [15:0]    BP_st_addr;
  logic [1:0]     BP_st_num;
  logic [23:0]    Line_width;
  logic [31:0]    ddr_st_addr_out;
  logic [23:0]    ddr_len;
  logic           ddr_conf;
  logic [255:0]   ddr_read_data;
  logic           ddr_read_valid;
  logic           ddr_read_ready;
  logic [1023:0]  BP_addr_out;
  logic [2047:0]  BP_data_out;
  logic [63:0]    BP_we_out;
  logic           idle;

  int n_checks = 0;
  int n_errors = 0;

  bp_load_control dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .conf            (conf),
    .data_ddr_byte   (data_ddr_byte),
    .ddr_st_addr     (ddr_st_addr),
    .BP_st_addr      (BP_st_addr),
    .BP_st_num       (BP_st_num),
    .Line_width      (Line_width),
    .ddr_st_addr_out (ddr_st_addr_out),
    .ddr_len         (ddr_len),
    .ddr_conf        (ddr_conf),
    .ddr_read_data   (ddr_read_data),
    .ddr_read_valid  (ddr_read_valid),
    .ddr_read_ready  (ddr_read_ready),
    .BP_addr_out     (BP_addr_out),
    .BP_data_out     (BP_data_out),
    .BP_we_out       (BP_we_out),
    .idle            (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] fill(input logic [7:0] v);
    return {32{v}};
  endfunction

  function automatic logic [63:0] mask_of(input int g);
    logic [63:0] mk = '0;
    for (int m = 0; m < 16; m++) mk[g + 4*m] = 1'b1;
    return mk;
  endfunction

  function automatic int bad_lanes(input logic [511:0] w);
    int bad = 0;
    for (int b = 0; b < 64; b++)
      if (BP_data_out[b*32 +: 32] !== w[(b/4)*32 +: 32]) bad++;
    return bad;
  endfunction

  function automatic int bad_addrs(input logic [15:0] a);
    int bad = 0;
    for (int b = 0; b < 64; b++)
      if (BP_addr_out[b*16 +: 16] !== a) bad++;
    return bad;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_conf(input string tag, input logic [23:0] lw, input logic [1:0] num,
                         input logic [15:0] sa, input logic [31:0] da, input logic [23:0] nbytes);
    Line_width    = lw;
    BP_st_num     = num;
    BP_st_addr    = sa;
    ddr_st_addr   = da;
    data_ddr_byte = nbytes;
    conf          = 1'b1;
    tick();
    conf          = 1'b0;
    // Scramble config inputs so only the latched copy can be in use.
    Line_width    = 24'hFFFFFF;
    BP_st_addr    = 16'hDEAD;
    BP_st_num     = ~num;
    check({tag, "_ddr_conf"}, 64'(ddr_conf), 64'd1);
    check({tag, "_ddr_addr"}, 64'(ddr_st_addr_out), 64'(da));
    check({tag, "_ddr_len"}, 64'(ddr_len), 64'(nbytes));
    check({tag, "_ready"}, 64'(ddr_read_ready), 64'(lw != 0));
    check({tag, "_busy"}, 64'(idle), 64'd0);
  endtask

  task automatic drive_beat(input string tag, input logic [255:0] d, input int gap);
    for (int i = 0; i < gap; i++) begin
      ddr_read_valid = 1'b0;
      tick();
    end
    ddr_read_data  = d;
    ddr_read_valid = 1'b1;
    check({tag, "_ready"}, 64'(ddr_read_ready), 64'd1);
    tick();
    ddr_read_valid = 1'b0;
  endtask

  task automatic expect_write(input string tag, input int g, input logic [15:0] a,
                              input logic [511:0] w);
    check({tag, "_we"}, BP_we_out, mask_of(g));
    check({tag, "_addr"}, 64'(BP_addr_out[15:0]), 64'(a));
    check({tag, "_addr_bad_slots"}, 64'(bad_addrs(a)), 64'd0);
    check({tag, "_data_bad_lanes"}, 64'(bad_lanes(w)), 64'd0);
  endtask

  task automatic send_pair(input string tag, input logic [255:0] lo, input logic [255:0] hi,
                           input int gap, input int g, input logic [15:0] a);
    drive_beat(tag, lo, gap);
    check({tag, "_half_no_we"}, BP_we_out, 64'd0);
    drive_beat(tag, hi, gap);
    expect_write(tag, g, a, {hi, lo});
  endtask

  initial begin
    rst_n          = 1'b0;
    conf           = 1'b0;
    data_ddr_byte  = '0;
    ddr_st_addr    = '0;
    BP_st_addr     = '0;
    BP_st_num      = '0;
    Line_width     = '0;
    ddr_read_data  = '0;
    ddr_read_valid = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_ddr_conf", 64'(ddr_conf), 64'd0);
    check("rst_ready", 64'(ddr_read_ready), 64'd0);
    check("rst_we", BP_we_out, 64'd0);
    check("rst_len", 64'(ddr_len), 64'd0);
    rst_n = 1'b1;
    tick();

    // Two lines of two words starting at group 1, address 0x10
    do_conf("t1", 24'd2, 2'd1, 16'h0010, 32'h1000_0000, 24'd256);
    tick();
    check("t1_conf_pulse_once", 64'(ddr_conf), 64'd0);
    send_pair("t1_w0", fill(8'h11), fill(8'h22), 0, 1, 16'h0010);
    send_pair("t1_w1", fill(8'h33), fill(8'h44), 0, 1, 16'h0011);
    send_pair("t1_w2", fill(8'h55), fill(8'h66), 0, 2, 16'h0010);
    send_pair("t1_w3", fill(8'h77), fill(8'h88), 0, 2, 16'h0011);
    check("t1_last_write_not_idle", 64'(idle), 64'd0);
    check("t1_done_ready", 64'(ddr_read_ready), 64'd0);
    tick();
    check("t1_idle", 64'(idle), 64'd1);
    check("t1_we_cleared", BP_we_out, 64'd0);

    // Valid while not ready must be ignored
    ddr_read_data  = fill(8'hFF);
    ddr_read_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ign_we", BP_we_out, 64'd0);
      check("ign_ready", 64'(ddr_read_ready), 64'd0);
    end
    ddr_read_valid = 1'b0;

    // Group wrap 3 -> 0, Line_width 1; A5/3C lane split
    do_conf("t2", 24'd1, 2'd3, 16'h0100, 32'h2000_0040, 24'd128);
    send_pair("t2_w0", fill(8'hA5), fill(8'h3C), 0, 3, 16'h0100);
    check("t2_lane0", 64'(BP_data_out[31:0]), 64'h0000_0000_A5A5_A5A5);
    check("t2_lane31", 64'(BP_data_out[31*32 +: 32]), 64'h0000_0000_A5A5_A5A5);
    check("t2_lane32", 64'(BP_data_out[32*32 +: 32]), 64'h0000_0000_3C3C_3C3C);
    check("t2_lane63", 64'(BP_data_out[63*32 +: 32]), 64'h0000_0000_3C3C_3C3C);
    send_pair("t2_w1", fill(8'h01), fill(8'h02), 0, 0, 16'h0100);
    check("t2_wrap_we_literal", BP_we_out, 64'h1111_1111_1111_1111);
    tick();
    tick();
    check("t2_idle", 64'(idle), 64'd1);

    // Valid every third cycle, address wraps past 0xFFFF
    do_conf("t3", 24'd2, 2'd0, 16'hFFFF, 32'h3000_0000, 24'd256);
    send_pair("t3_w0", fill(8'h10), fill(8'h20), 2, 0, 16'hFFFF);
    send_pair("t3_w1", fill(8'h30), fill(8'h40), 2, 0, 16'h0000);
    send_pair("t3_w2", fill(8'h50), fill(8'h60), 2, 1, 16'hFFFF);
    send_pair("t3_w3", fill(8'h70), fill(8'h80), 2, 1, 16'h0000);
    tick();
    check("t3_idle", 64'(idle), 64'd1);

    // Line_width 0: no ready, no writes, working drops after one cycle
    do_conf("t4", 24'd0, 2'd2, 16'h0040, 32'h4000_0000, 24'd0);
    ddr_read_data  = fill(8'h99);
    ddr_read_valid = 1'b1;
    tick();
    check("t4_trailing_busy", 64'(idle), 64'd0);
    check("t4_we", BP_we_out, 64'd0);
    tick();
    check("t4_idle", 64'(idle), 64'd1);
    check("t4_we2", BP_we_out, 64'd0);
    check("t4_ready", 64'(ddr_read_ready), 64'd0);
    ddr_read_valid = 1'b0;

    // Restart mid-transfer: the stale half-packed beat must be dropped
    do_conf("t5a", 24'd1, 2'd2, 16'h0030, 32'h5000_0000, 24'd128);
    drive_beat("t5_stale", fill(8'hEE), 0);
    check("t5_stale_no_we", BP_we_out, 64'd0);
    do_conf("t5b", 24'd1, 2'd0, 16'h0020, 32'h5000_1000, 24'd128);
    check("t5_restart_no_we", BP_we_out, 64'd0);
    send_pair("t5_w0", fill(8'hC1), fill(8'hC2), 0, 0, 16'h0020);
    send_pair("t5_w1", fill(8'hC3), fill(8'hC4), 0, 1, 16'h0020);
    tick();
    check("t5_idle", 64'(idle), 64'd1);

    // Reset after three writes aborts immediately
    do_conf("t6", 24'd4, 2'd0, 16'h0040, 32'h6000_0000, 24'd512);
    send_pair("t6_w0", fill(8'hD1), fill(8'hD2), 0, 0, 16'h0040);
    send_pair("t6_w1", fill(8'hD3), fill(8'hD4), 0, 0, 16'h0041);
    send_pair("t6_w2", fill(8'hD5), fill(8'hD6), 0, 0, 16'h0042);
    rst_n          = 1'b0;
    ddr_read_data  = fill(8'hD7);
    ddr_read_valid = 1'b1;
    tick();
    check("t6_rst_we", BP_we_out, 64'd0);
    check("t6_rst_idle", 64'(idle), 64'd1);
    check("t6_rst_ready", 64'(ddr_read_ready), 64'd0);
    check("t6_rst_addr", 64'(BP_addr_out[15:0]), 64'd0);
    check("t6_rst_len", 64'(ddr_len), 64'd0);
    rst_n          = 1'b1;
    ddr_read_valid = 1'b0;
    tick();
    check("t6_post_rst_idle", 64'(idle), 64'd1);

    // Fresh transfer after reset
    do_conf("t7", 24'd1, 2'd2, 16'h0005, 32'h7000_0000, 24'd128);
    send_pair("t7_w0", fill(8'hE1), fill(8'hE2), 0, 2, 16'h0005);
    send_pair("t7_w1", fill(8'hE3), fill(8'hE4), 0, 3, 16'h0005);
    tick();
    check("t7_idle", 64'(idle), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bp_load_control.md
BP_LOAD_CONTROL -- requirements
Module: bp_load_control

Interface
REQ-001 SHALL have parameter X_MAC, default 4, buffer groups per mesh lane.
REQ-002 SHALL have parameter X_MESH, default 16, 32-bit lanes per packed word.
REQ-003 SHALL have parameters DDR_ADDR_LEN 32, ADDR_LEN 16, DATA_LEN 32, SINGLE_LEN 24, C_AXI_DATA_WIDTH 256, BUFFER_NUM 64 (= X_MAC*X_MESH).
REQ-004 SHALL have clk  in  1  clock; reset rst_n, synchronous, active-low; clock clk.
REQ-005 SHALL have rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have conf  in  1  one-cycle start pulse; samples all config inputs.
REQ-007 SHALL have data_ddr_byte  in  SINGLE_LEN  DDR read length in bytes.
REQ-008 SHALL have ddr_st_addr  in  DDR_ADDR_LEN  DDR read start address.
REQ-009 SHALL have BP_st_addr  in  ADDR_LEN  first buffer address of each line.
REQ-010 SHALL have BP_st_num  in  2  first buffer group n.
REQ-011 SHALL have Line_width  in  SINGLE_LEN  packed words per line.
REQ-012 SHALL have ddr_st_addr_out  out  DDR_ADDR_LEN, ddr_len  out  SINGLE_LEN, ddr_conf  out  1: DDR read request.
REQ-013 SHALL have ddr_read_data  in  C_AXI_DATA_WIDTH, ddr_read_valid  in  1, ddr_read_ready  out  1: beat stream.
REQ-014 SHALL have BP_addr_out  out  ADDR_LEN*BUFFER_NUM, BP_data_out  out  DATA_LEN*BUFFER_NUM, BP_we_out  out  BUFFER_NUM.
REQ-015 SHALL have idle  out  1  high when no transfer is in progress.

Function
REQ-016 On conf: latch config, set working, clear counters/pack state; ddr_st_addr_out<=ddr_st_addr, ddr_len<=data_ddr_byte, ddr_conf<=1 next edge.
REQ-017 ddr_conf SHALL be high exactly one cycle per conf.
REQ-018 ddr_read_ready SHALL equal working && beats_accepted < 4*Line_width; beat accepted when valid && ready.
REQ-019 Beats SHALL pack in pairs: first beat -> word[255:0], second -> word[511:256].
REQ-020 Cycle after the second beat of a pair is accepted, one buffer write SHALL issue (latency 1).
REQ-021 Write: BP_we_out[b]=1 only for b = n + m*X_MAC, m=0..X_MESH-1, n=current group; all other we bits 0.
REQ-022 BP_data_out lane b SHALL carry word[m*DATA_LEN +: DATA_LEN], b = n + m*X_MAC, broadcast to every n.
REQ-023 BP_addr_out SHALL drive the current address to all BUFFER_NUM slots.
REQ-024 Address SHALL start at BP_st_addr and increment by 1 per write within a line.
REQ-025 After Line_width writes on line 0: group n<=n+1 (mod 4, 3 wraps to 0), address<=BP_st_addr, line<=1.
REQ-026 After Line_width writes on line 1: working<=0, address/counters<=0; total writes = 2*Line_width.
REQ-027 idle SHALL be !working && !working_d1 (one extra cycle covers the final write).
REQ-028 ddr_read_valid while ready low SHALL be ignored; beats are never dropped while ready high.
REQ-029 Line_width=0: no ddr_read_ready, no writes; working clears the cycle after conf.
REQ-030 conf while working SHALL restart; any half-packed beat is discarded, no write for it.
REQ-031 Address arithmetic SHALL be ADDR_LEN wide, wrapping modulo 2^ADDR_LEN.

Reset
REQ-032 rst_n low SHALL clear working, ddr_conf, ddr_len, ddr_st_addr_out, BP_we_out, BP_addr_out, BP_data_out, pack state, counters; idle=1.
REQ-033 Reset mid-transfer SHALL abort immediately with no further writes; next conf starts fresh.

Structure
REQ-034 Package bp_ctrl_pkg SHALL hold default parameter constants and the lane-to-buffer index function b = n + m*X_MAC.
REQ-035 Sub-module bp_beat_pack SHALL do 256->512 pairing, output word plus one-cycle word_valid.

Verification
REQ-036 Line_width=2, BP_st_num=1, BP_st_addr=0x10, 8 beats -> writes group1 @0x10,0x11, then group2 @0x10,0x11; idle after.
REQ-037 BP_st_num=3, Line_width=1 -> line 1 writes group 0 (wrap); BP_we_out bits 0,4,...,60 only.
REQ-038 Beat0=all 0xA5, beat1=all 0x3C -> lanes m<8 get 0xA5A5A5A5, m>=8 get 0x3C3C3C3C.
REQ-039 Gaps in ddr_read_valid (valid every 3rd cycle) -> same writes, each 1 cycle after second beat.
REQ-040 conf after 1 beat mid-transfer, then 4 new beats -> stale beat discarded, writes reflect new data only.
REQ-041 rst_n low after 3 writes -> BP_we_out 0 next cycle, idle=1, ddr_read_ready=0.
